// File: rtl/m_ice40sim_stimgen.sv
// ---------------------------------------------------------------------------
// m_ice40sim_stimgen
//
// Stimulus generator placed in front of the midgetv iCE40 simulation top.
// It stretches the incoming reset into a clean core reset and then raises
// the machine external interrupt (meip) periodically. Each interrupt is held
// until acknowledged (or until a hold timeout expires when the optional
// timeout feature is compiled in). Acknowledged interrupts are counted so
// a Verilator test can check interrupt throughput.
//
// Optional feature macro: M_ICE40SIM_STIMGEN_TIMEOUT_EN
//   defined   : meip is dropped after IRQHOLD cycles without ack, tmo is set
//   undefined : meip is held until ack, tmo is constant 0, IRQHOLD unused
//
// Parameters:
//   RSTCYCLES  cycles RST_O stays high after RST_I falls (1..65535)
//   IRQPERIOD  idle cycles before each meip rise        (1..2^20-1)
//   IRQHOLD    max meip high time with timeout enabled  (1..65535)
//   IRQCOUNT   number of interrupts, 0 (or >= 65536) = unlimited
//
// Ports:
//   CLK_I    in   1   clock
//   RST_I    in   1   synchronous active-high reset
//   irq_ack  in   1   acknowledge, clears a pending meip
//   RST_O    out  1   stretched core reset
//   meip     out  1   machine external interrupt pending (level)
//   irqcnt   out  16  acknowledged interrupts, saturating
//   tmo      out  1   sticky: some interrupt timed out
//   done     out  1   IRQCOUNT interrupts have completed
// ---------------------------------------------------------------------------
module m_ice40sim_stimgen #(
   parameter int unsigned RSTCYCLES = 16,
   parameter int unsigned IRQPERIOD = 1000,
   parameter int unsigned IRQHOLD   = 64,
   parameter int unsigned IRQCOUNT  = 0
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        irq_ack,
   output logic        RST_O,
   output logic        meip,
   output logic [15:0] irqcnt,
   output logic        tmo,
   output logic        done
);

   typedef enum logic [1:0] {
      S_RST  = 2'd0,
      S_IDLE = 2'd1,
      S_IRQ  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Counters compare against "last value" so a transition happens on the
   // N-th counted edge with the counter starting at zero.
   localparam logic [15:0] RST_LAST    = 16'(RSTCYCLES - 32'd1);
   localparam logic [19:0] PER_LAST    = 20'(IRQPERIOD - 32'd1);
   localparam bit          CNT_LIMITED = (IRQCOUNT != 32'd0) && (IRQCOUNT < 32'd65536);
   localparam logic [15:0] CNT_LIMIT   = 16'(IRQCOUNT);
`ifdef M_ICE40SIM_STIMGEN_TIMEOUT_EN
   localparam logic [15:0] HOLD_LAST   = 16'(IRQHOLD - 32'd1);
`endif

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

   state_t      state_r,   state_s;
   logic        rst_o_r,   rst_o_s;
   logic        meip_r,    meip_s;
   logic [15:0] irqcnt_r,  irqcnt_s;
   logic        tmo_r,     tmo_s;
   logic        done_r,    done_s;
   logic [15:0] stretch_r, stretch_s;
   logic [19:0] period_r,  period_s;
   logic [15:0] compl_r,   compl_s;
   logic        last_s;
`ifdef M_ICE40SIM_STIMGEN_TIMEOUT_EN
   logic [15:0] hold_r,    hold_s;
`endif

   // Next-state and next-register computation for the whole generator.
   always_comb begin
      state_s   = state_r;
      rst_o_s   = rst_o_r;
      meip_s    = meip_r;
      irqcnt_s  = irqcnt_r;
      tmo_s     = tmo_r;
      done_s    = done_r;
      stretch_s = stretch_r;
      period_s  = period_r;
      compl_s   = compl_r;
`ifdef M_ICE40SIM_STIMGEN_TIMEOUT_EN
      hold_s    = hold_r;
`endif
      // True when the interrupt completing now is the final one.
      last_s    = CNT_LIMITED && (sat_inc16(compl_r) == CNT_LIMIT);

      case (state_r)
         S_RST: begin
            meip_s = 1'b0;
            if (stretch_r == RST_LAST) begin
               state_s   = S_IDLE;
               rst_o_s   = 1'b0;
               stretch_s = 16'd0;
               period_s  = 20'd0;
            end else begin
               rst_o_s   = 1'b1;
               stretch_s = stretch_r + 16'd1;
            end
         end
         S_IDLE: begin
            if (period_r == PER_LAST) begin
               state_s  = S_IRQ;
               meip_s   = 1'b1;
               period_s = 20'd0;
`ifdef M_ICE40SIM_STIMGEN_TIMEOUT_EN
               hold_s   = 16'd0;
`endif
            end else begin
               period_s = period_r + 20'd1;
            end
         end
         S_IRQ: begin
            // Ack is checked first so it wins over a coincident timeout.
            if (irq_ack) begin
               meip_s   = 1'b0;
               irqcnt_s = sat_inc16(irqcnt_r);
               compl_s  = sat_inc16(compl_r);
               if (last_s) begin
                  state_s = S_DONE;
                  done_s  = 1'b1;
               end else begin
                  state_s  = S_IDLE;
                  period_s = 20'd0;
               end
            end
`ifdef M_ICE40SIM_STIMGEN_TIMEOUT_EN
            else if (hold_r == HOLD_LAST) begin
               meip_s  = 1'b0;
               tmo_s   = 1'b1;
               compl_s = sat_inc16(compl_r);
               if (last_s) begin
                  state_s = S_DONE;
                  done_s  = 1'b1;
               end else begin
                  state_s  = S_IDLE;
                  period_s = 20'd0;
               end
            end else begin
               hold_s = hold_r + 16'd1;
            end
`else
            else begin
               meip_s = 1'b1;
            end
`endif
         end
         S_DONE: begin
            meip_s = 1'b0;
            done_s = 1'b1;
         end
         default: begin
            state_s = S_RST;
            rst_o_s = 1'b1;
            meip_s  = 1'b0;
            done_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_r   <= S_RST;
         rst_o_r   <= 1'b1;
         meip_r    <= 1'b0;
         irqcnt_r  <= 16'd0;
         tmo_r     <= 1'b0;
         done_r    <= 1'b0;
         stretch_r <= 16'd0;
         period_r  <= 20'd0;
         compl_r   <= 16'd0;
`ifdef M_ICE40SIM_STIMGEN_TIMEOUT_EN
         hold_r    <= 16'd0;
`endif
      end else begin
         state_r   <= state_s;
         rst_o_r   <= rst_o_s;
         meip_r    <= meip_s;
         irqcnt_r  <= irqcnt_s;
         tmo_r     <= tmo_s;
         done_r    <= done_s;
         stretch_r <= stretch_s;
         period_r  <= period_s;
         compl_r   <= compl_s;
`ifdef M_ICE40SIM_STIMGEN_TIMEOUT_EN
         hold_r    <= hold_s;
`endif
      end
   end

   assign RST_O  = rst_o_r;
   assign meip   = meip_r;
   assign irqcnt = irqcnt_r;
   assign tmo    = tmo_r;
   assign done   = done_r;

endmodule

// File: tb/tb_m_ice40sim_stimgen.sv
// ---------------------------------------------------------------------------
// Self-checking bench for m_ice40sim_stimgen. A behavioural model tracks
// remaining-cycle countdowns and interrupt totals; every cycle the DUT
// outputs are compared against it, with directed timing measurements on top.
// ---------------------------------------------------------------------------
module tb_m_ice40sim_stimgen;

   localparam int RSTC = 16;
   localparam int PER  = 10;
   localparam int HOLD = 5;
   localparam int CNT  = 3;

`ifdef M_ICE40SIM_STIMGEN_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_i;
   logic        irq_ack;
   logic        rst_o;
   logic        meip;
   logic [15:0] irqcnt;
   logic        tmo;
   logic        done;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit m_rst, m_meip, m_tmo, m_done;
   int m_cnt, m_left, m_hold, m_compl;

   m_ice40sim_stimgen #(
      .RSTCYCLES(RSTC),
      .IRQPERIOD(PER),
      .IRQHOLD  (HOLD),
      .IRQCOUNT (CNT)
   ) dut (
      .CLK_I  (clk),
      .RST_I  (rst_i),
      .irq_ack(irq_ack),
      .RST_O  (rst_o),
      .meip   (meip),
      .irqcnt (irqcnt),
      .tmo    (tmo),
      .done   (done)
   );

   // free-running clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock edge of the behavioural model.
   task automatic model_step(input bit r, input bit a);
      if (r) begin
         m_rst = 1'b1; m_meip = 1'b0; m_tmo = 1'b0; m_done = 1'b0;
         m_cnt = 0; m_compl = 0; m_hold = 0; m_left = RSTC;
      end else if (m_done) begin
         m_meip = 1'b0;
      end else if (m_rst) begin
         m_left--;
         if (m_left == 0) begin
            m_rst  = 1'b0;
            m_left = PER;
         end
      end else if (!m_meip) begin
         m_left--;
         if (m_left == 0) begin
            m_meip = 1'b1;
            m_hold = 0;
         end
      end else begin
         m_hold++;
         if (a || (TMO_EN && m_hold == HOLD)) begin
            if (a) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            else   m_tmo = 1'b1;
            m_meip = 1'b0;
            m_compl++;
            if (CNT != 0 && m_compl >= CNT) m_done = 1'b1;
            else                            m_left = PER;
         end
      end
   endtask

   // Drive inputs, clock once, then compare every output on the falling edge.
   task automatic cycle(input bit r, input bit a);
      rst_i   = r;
      irq_ack = a;
      @(posedge clk);
      model_step(r, a);
      @(negedge clk);
      chk("RST_O",  rst_o,  m_rst);
      chk("meip",   meip,   m_meip);
      chk("irqcnt", irqcnt, m_cnt);
      chk("tmo",    tmo,    m_tmo);
      chk("done",   done,   m_done);
   endtask

   task automatic wait_meip(input int bound, output int n);
      n = 0;
      while (meip !== 1'b1 && n < bound) begin
         cycle(1'b0, 1'b0);
         n++;
      end
      if (meip !== 1'b1) chk("wait_meip_bound", 0, 1);
   endtask

   task automatic wait_rst_low(input int bound, output int n);
      n = 1;
      while (rst_o === 1'b1 && n < bound) begin
         cycle(1'b0, 1'b0);
         if (rst_o === 1'b1) n++;
      end
      if (rst_o !== 1'b0) chk("wait_rst_bound", 0, 1);
   endtask

   task automatic do_reset(input int len);
      repeat (len) cycle(1'b1, 1'b0);
   endtask

   initial begin
      int n;
      rst_i   = 1'b1;
      irq_ack = 1'b0;

      // reset stretch and first interrupt gap
      do_reset(3);
      wait_rst_low(100, n);
      chk("rst_stretch", n, RSTC);
      wait_meip(100, n);
      chk("first_gap", n, PER);

      // periodic ack two cycles after each rise, finite count
      for (int k = 1; k <= CNT; k++) begin
         cycle(1'b0, 1'b0);
         cycle(1'b0, 1'b1);
         chk("irqcnt_seq", irqcnt, k);
         if (k < CNT) begin
            wait_meip(100, n);
            chk("irq_gap", n, PER);
         end
      end
      chk("done_set", done, 1);
      for (int i = 0; i < 1000; i++) cycle(1'b0, 1'($urandom_range(0, 1)));
      chk("done_irqcnt", irqcnt, CNT);
      chk("done_meip", meip, 0);

`ifdef M_ICE40SIM_STIMGEN_TIMEOUT_EN
      // timeout without ack
      do_reset(2);
      wait_rst_low(100, n);
      wait_meip(100, n);
      n = 0;
      while (meip === 1'b1 && n < 100) begin
         cycle(1'b0, 1'b0);
         n++;
      end
      chk("hold_len", n, HOLD);
      chk("tmo_set", tmo, 1);
      chk("tmo_irqcnt", irqcnt, 0);
      wait_meip(100, n);
      chk("gap_after_tmo", n, PER);
      // ack on the last held edge wins over timeout
      do_reset(2);
      wait_rst_low(100, n);
      wait_meip(100, n);
      repeat (HOLD - 1) cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      chk("ack_wins_tmo", tmo, 0);
      chk("ack_wins_cnt", irqcnt, 1);
`else
      // no timeout: meip held indefinitely
      do_reset(2);
      wait_rst_low(100, n);
      wait_meip(100, n);
      repeat (10000) cycle(1'b0, 1'b0);
      chk("held_meip", meip, 1);
      chk("held_tmo", tmo, 0);
      cycle(1'b0, 1'b1);
      chk("late_ack_meip", meip, 0);
      chk("late_ack_cnt", irqcnt, 1);
`endif

      // spurious ack in idle, then reset mid-interrupt
      do_reset(2);
      wait_rst_low(100, n);
      wait_meip(100, n);
      cycle(1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b1);
      chk("spurious_ack", irqcnt, 1);
      wait_meip(100, n);
      cycle(1'b1, 1'b0);
      chk("midrst_meip", meip, 0);
      chk("midrst_rsto", rst_o, 1);
      chk("midrst_cnt", irqcnt, 0);
      chk("midrst_tmo", tmo, 0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
